// File: rtl/atpg_exhaustive_bist.sv
`timescale 1ns/1ps
// atpg_exhaustive_bist
// Exhaustive-pattern BIST controller for a combinational CUT. Walks pat_out through
// 0..2^N_IN-1, samples resp_in RESP_LAT cycles after each pattern is applied, folds every
// response into a MISR and reports signature == golden_sig when the sweep completes.
//
//   state  | meaning
//   IDLE   | waiting for start; pattern/signature cleared
//   RUN    | current pattern applied (capture here when RESP_LAT=0)
//   WAIT   | waiting RESP_LAT cycles for the CUT response to settle
//   DONE   | sweep complete; pattern, signature and pass held
module atpg_exhaustive_bist #(
   parameter int                N_IN      = 15,
   parameter int                N_OUT     = 2,
   parameter int                SIG_W     = 16,
   parameter logic [SIG_W-1:0]  MISR_POLY = 16'h100B,
   parameter int                RESP_LAT  = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [SIG_W-1:0]  golden_sig,
   input  logic [N_OUT-1:0]  resp_in,
   output logic [N_IN-1:0]   pat_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [SIG_W-1:0]  signature
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [3:0] LAT_TC = 4'(RESP_LAT);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [N_IN-1:0]   r_pat;
   logic [N_IN-1:0]   w_pat_nxt;
   logic [SIG_W-1:0]  r_sig;
   logic [SIG_W-1:0]  w_sig_nxt;
   logic [SIG_W-1:0]  w_sig_upd;
   logic [SIG_W-1:0]  w_resp_ext;
   logic [3:0]        r_lat;
   logic [3:0]        w_lat_nxt;
   logic              r_busy;
   logic              r_done;
   logic              r_pass;
   logic              w_pass_nxt;
   logic              w_capture;
   logic              w_pat_last;

   assign w_resp_ext = SIG_W'(resp_in);
   assign w_sig_upd  = {r_sig[SIG_W-2:0], 1'b0}
                     ^ (r_sig[SIG_W-1] ? MISR_POLY : '0)
                     ^ w_resp_ext;
   assign w_pat_last = &r_pat;

   // Next-state, capture/advance and pass decision.
   always_comb begin
      w_state_nxt = r_state;
      w_pat_nxt   = r_pat;
      w_sig_nxt   = r_sig;
      w_lat_nxt   = r_lat;
      w_pass_nxt  = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_RUN;
               w_pat_nxt   = '0;
               w_sig_nxt   = '0;
               w_lat_nxt   = '0;
            end
         end
         S_RUN: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
               w_pat_nxt   = '0;
               w_sig_nxt   = '0;
               w_lat_nxt   = '0;
            end else if (RESP_LAT == 0) begin
               w_capture = 1'b1;
            end else begin
               w_state_nxt = S_WAIT;
               w_lat_nxt   = 4'd1;
            end
         end
         S_WAIT: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
               w_pat_nxt   = '0;
               w_sig_nxt   = '0;
               w_lat_nxt   = '0;
            end else if (r_lat == LAT_TC) begin
               w_capture = 1'b1;
            end else begin
               w_lat_nxt = r_lat + 4'd1;
            end
         end
         S_DONE: begin
            w_pass_nxt = r_pass;
            if (start) begin
               w_state_nxt = S_RUN;
               w_pat_nxt   = '0;
               w_sig_nxt   = '0;
               w_lat_nxt   = '0;
               w_pass_nxt  = 1'b0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // One MISR update per pattern; the last pattern ends the sweep instead of wrapping.
      if (w_capture) begin
         w_sig_nxt = w_sig_upd;
         w_lat_nxt = '0;
         if (w_pat_last) begin
            w_state_nxt = S_DONE;
            w_pass_nxt  = (w_sig_upd == golden_sig);
         end else begin
            w_state_nxt = S_RUN;
            w_pat_nxt   = r_pat + N_IN'(1);
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath and status flags, registered so outputs come straight from flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pat  <= '0;
         r_sig  <= '0;
         r_lat  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_pass <= 1'b0;
      end else begin
         r_pat  <= w_pat_nxt;
         r_sig  <= w_sig_nxt;
         r_lat  <= w_lat_nxt;
         r_busy <= (w_state_nxt == S_RUN) || (w_state_nxt == S_WAIT);
         r_done <= (w_state_nxt == S_DONE);
         r_pass <= w_pass_nxt;
      end
   end

   assign pat_out   = r_pat;
   assign signature = r_sig;
   assign busy      = r_busy;
   assign done      = r_done;
   assign pass      = r_pass;

endmodule

// File: tb/tb_atpg_exhaustive_bist.sv
`timescale 1ns/1ps
// Bench for atpg_exhaustive_bist: three instances (small zero-latency, small RESP_LAT=2,
// full default size with a behavioural CUT) checked against a bench-side MISR model.
module tb_atpg_exhaustive_bist;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   int checks   = 0;
   int failures = 0;

   // Instance A: N_IN=3, N_OUT=1, SIG_W=4, POLY=3, RESP_LAT=0
   logic       a_start, a_abort;
   logic [3:0] a_golden;
   logic [0:0] a_resp;
   logic [2:0] a_pat;
   logic       a_busy, a_done, a_pass;
   logic [3:0] a_sig;
   int         a_mode;

   // Instance B: N_IN=2, N_OUT=1, SIG_W=4, POLY=3, RESP_LAT=2
   logic       b_start, b_abort;
   logic [3:0] b_golden;
   logic [0:0] b_resp;
   logic [1:0] b_pat;
   logic       b_busy, b_done, b_pass;
   logic [3:0] b_sig;

   // Instance C: default parameters with a behavioural CUT
   logic        c_start, c_abort, c_stuck;
   logic [15:0] c_golden;
   logic [1:0]  c_resp;
   logic [14:0] c_pat;
   logic        c_busy, c_done, c_pass;
   logic [15:0] c_sig;

   atpg_exhaustive_bist #(.N_IN(3), .N_OUT(1), .SIG_W(4), .MISR_POLY(4'h3), .RESP_LAT(0)) u_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .golden_sig(a_golden),
      .resp_in(a_resp), .pat_out(a_pat), .busy(a_busy), .done(a_done), .pass(a_pass),
      .signature(a_sig));

   atpg_exhaustive_bist #(.N_IN(2), .N_OUT(1), .SIG_W(4), .MISR_POLY(4'h3), .RESP_LAT(2)) u_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .golden_sig(b_golden),
      .resp_in(b_resp), .pat_out(b_pat), .busy(b_busy), .done(b_done), .pass(b_pass),
      .signature(b_sig));

   atpg_exhaustive_bist u_c (
      .clk(clk), .rst_n(rst_n), .start(c_start), .abort(c_abort), .golden_sig(c_golden),
      .resp_in(c_resp), .pat_out(c_pat), .busy(c_busy), .done(c_done), .pass(c_pass),
      .signature(c_sig));

   function automatic logic resp_a(input int mode, input logic [2:0] p);
      if (mode == 0) return 1'b0;
      if (mode == 1) return 1'b1;
      return ^p;
   endfunction

   function automatic logic [1:0] cut_f(input logic [14:0] p);
      logic [1:0] r;
      r[0] = p[0] ^ p[5] ^ (p[3] & p[14]);
      r[1] = (p[2] | p[9]) ^ p[13];
      return r;
   endfunction

   assign a_resp[0] = resp_a(a_mode, a_pat);
   assign b_resp[0] = 1'b1;
   assign c_resp    = cut_f(c_pat) & {1'b1, ~c_stuck};

   // Bit-serial MISR reference: bit i takes bit i-1, tap i when the msb falls out, and resp bit i.
   function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] r,
                                             input logic [31:0] poly, input int w);
      logic [31:0] n;
      logic        fb;
      fb = s[w-1];
      n  = '0;
      for (int i = 0; i < w; i++) begin
         if (i > 0) n[i] = s[i-1];
         n[i] = n[i] ^ (fb & poly[i]) ^ r[i];
      end
      return n;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0] pat;
      logic [3:0] sig;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      int         mode;
      logic [3:0] golden;
      logic [3:0] exp_sig;
      logic       exp_pass;
      bit         hold;
   } vec_t;

   task automatic sb_pop_check(input string nm, input logic [3:0] pat, input logic [3:0] sig);
      exp_t e;
      if (sb_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s_sb_empty actual=busy expected=no_pending_pattern", nm);
      end else begin
         e = sb_q.pop_front();
         chk({nm, "_pat"}, 32'(pat), 32'(e.pat));
         chk({nm, "_sig"}, 32'(sig), 32'(e.sig));
      end
   endtask

   task automatic run_a(input vec_t v);
      logic [3:0] s;
      exp_t       e;
      int         nb;
      a_mode   = v.mode;
      a_golden = v.golden;
      sb_q.delete();
      s = '0;
      for (int p = 0; p < 8; p++) begin
         e.pat = 4'(p);
         e.sig = s;
         sb_q.push_back(e);
         s = 4'(misr_step(32'(s), 32'(resp_a(v.mode, 3'(p))), 32'h3, 4));
      end
      @(negedge clk) a_start = 1'b1;
      @(negedge clk) if (!v.hold) a_start = 1'b0;
      nb = 0;
      for (int c = 0; c < 40 && !a_done; c++) begin
         if (a_busy) begin
            nb++;
            sb_pop_check("a", {1'b0, a_pat}, a_sig);
            chk("a_pass_while_busy", 32'(a_pass), 32'd0);
         end
         @(negedge clk);
      end
      a_start = 1'b0;
      chk("a_busy_cycles", 32'(nb), 32'd8);
      chk("a_sb_drained", 32'(sb_q.size()), 32'd0);
      chk("a_done", 32'(a_done), 32'd1);
      chk("a_final_sig", 32'(a_sig), 32'(v.exp_sig));
      chk("a_final_sig_model", 32'(a_sig), 32'(s));
      chk("a_pass", 32'(a_pass), 32'(v.exp_pass));
   endtask

   task automatic run_b(input logic [3:0] golden, input logic exp_pass);
      logic [3:0] s;
      exp_t       e;
      int         nb;
      b_golden = golden;
      sb_q.delete();
      s = '0;
      for (int p = 0; p < 4; p++) begin
         for (int k = 0; k < 3; k++) begin
            e.pat = 4'(p);
            e.sig = s;
            sb_q.push_back(e);
         end
         s = 4'(misr_step(32'(s), 32'd1, 32'h3, 4));
      end
      @(negedge clk) b_start = 1'b1;
      @(negedge clk) b_start = 1'b0;
      nb = 0;
      for (int c = 0; c < 60 && !b_done; c++) begin
         if (b_busy) begin
            nb++;
            sb_pop_check("b", {2'b00, b_pat}, b_sig);
         end
         @(negedge clk);
      end
      chk("b_busy_cycles", 32'(nb), 32'd12);
      chk("b_sb_drained", 32'(sb_q.size()), 32'd0);
      chk("b_done", 32'(b_done), 32'd1);
      chk("b_final_sig", 32'(b_sig), 32'hF);
      chk("b_pass", 32'(b_pass), 32'(exp_pass));
   endtask

   task automatic run_c(input logic stuck, input logic [15:0] gold, input logic exp_pass);
      int nb;
      c_stuck  = stuck;
      c_golden = gold;
      @(negedge clk) c_start = 1'b1;
      @(negedge clk) c_start = 1'b0;
      nb = 0;
      for (int c = 0; c < 40000 && !c_done; c++) begin
         if (c_busy) nb++;
         @(negedge clk);
      end
      chk("c_busy_cycles", 32'(nb), 32'd32768);
      chk("c_done", 32'(c_done), 32'd1);
      chk("c_pass", 32'(c_pass), 32'(exp_pass));
      if (!stuck) chk("c_sig", 32'(c_sig), 32'(gold));
   endtask

   vec_t       vecs[5];
   logic [15:0] c_gold;
   int          guard;

   initial begin
      vecs[0] = '{mode: 0, golden: 4'h0, exp_sig: 4'h0, exp_pass: 1'b1, hold: 1'b0};
      vecs[1] = '{mode: 1, golden: 4'hD, exp_sig: 4'hD, exp_pass: 1'b1, hold: 1'b1};
      vecs[2] = '{mode: 1, golden: 4'hE, exp_sig: 4'hD, exp_pass: 1'b0, hold: 1'b0};
      vecs[3] = '{mode: 2, golden: 4'h3, exp_sig: 4'h3, exp_pass: 1'b1, hold: 1'b0};
      vecs[4] = '{mode: 2, golden: 4'h0, exp_sig: 4'h3, exp_pass: 1'b0, hold: 1'b0};

      c_gold = '0;
      for (int p = 0; p < 32768; p++)
         c_gold = 16'(misr_step(32'(c_gold), 32'(cut_f(15'(p))), 32'h100B, 16));

      a_start = 0; a_abort = 0; a_golden = 0; a_mode = 0;
      b_start = 0; b_abort = 0; b_golden = 0;
      c_start = 0; c_abort = 0; c_golden = 0; c_stuck = 0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_a_pat", 32'(a_pat), 32'd0);
      chk("rst_a_sig", 32'(a_sig), 32'd0);
      chk("rst_a_busy", 32'(a_busy), 32'd0);
      chk("rst_a_done", 32'(a_done), 32'd0);
      chk("rst_a_pass", 32'(a_pass), 32'd0);
      chk("rst_c_sig", 32'(c_sig), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_a_busy", 32'(a_busy), 32'd0);

      // table-driven runs; each run after the first restarts from DONE
      for (int i = 0; i < 5; i++) run_a(vecs[i]);

      // abort ignored in DONE; pass and signature held
      @(negedge clk) a_abort = 1'b1;
      repeat (2) @(negedge clk);
      a_abort = 1'b0;
      chk("done_abort_done", 32'(a_done), 32'd1);
      chk("done_abort_sig", 32'(a_sig), 32'h3);
      chk("done_abort_pass", 32'(a_pass), 32'd0);

      // abort at pattern 5
      a_mode = 1;
      @(negedge clk) a_start = 1'b1;
      @(negedge clk) a_start = 1'b0;
      guard = 0;
      while (a_pat != 3'd5 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk("abort_reached_pat5", 32'(a_pat), 32'd5);
      chk("abort_sig_before", 32'(a_sig), 32'hC);
      a_abort = 1'b1;
      @(negedge clk) a_abort = 1'b0;
      chk("abort_busy", 32'(a_busy), 32'd0);
      chk("abort_done", 32'(a_done), 32'd0);
      chk("abort_pat", 32'(a_pat), 32'd0);
      chk("abort_sig", 32'(a_sig), 32'd0);
      repeat (3) @(negedge clk);
      chk("abort_done_stays0", 32'(a_done), 32'd0);

      // start and abort together in IDLE: start wins; then abort in RUN
      a_start = 1'b1; a_abort = 1'b1;
      @(negedge clk) a_start = 1'b0;
      chk("start_wins_busy", 32'(a_busy), 32'd1);
      chk("start_wins_pat", 32'(a_pat), 32'd0);
      @(negedge clk) a_abort = 1'b0;
      chk("abort_run_busy", 32'(a_busy), 32'd0);
      chk("abort_run_pat", 32'(a_pat), 32'd0);

      run_a(vecs[0]);

      // async reset mid-run, then identical re-run
      a_mode = 2;
      @(negedge clk) a_start = 1'b1;
      @(negedge clk) a_start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_pat", 32'(a_pat), 32'd0);
      chk("midrst_sig", 32'(a_sig), 32'd0);
      chk("midrst_busy", 32'(a_busy), 32'd0);
      chk("midrst_done", 32'(a_done), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      run_a(vecs[3]);

      // RESP_LAT=2 instance
      run_b(4'hE, 1'b0);
      run_b(4'hF, 1'b1);

      // full-size runs: good CUT, then stuck-at-0 on CUT output 0
      run_c(1'b0, c_gold, 1'b1);
      run_c(1'b1, c_gold, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
